// File: rtl/lu_sequencer.sv
// Initiator-side controller for a bitwise logic unit: takes one operand pair,
// steps the LU through NOR/OR/XOR/XNOR and returns the four results as one word.
module lu_sequencer #(
  parameter int WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic [WIDTH-1:0]     lu_a,
  output logic [WIDTH-1:0]     lu_b,
  output logic [1:0]           lu_op,
  input  logic [WIDTH-1:0]     lu_res,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*WIDTH-1:0]   out_data,
  output logic                 out_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_nx;
  logic [1:0]         opcnt;
  logic [WIDTH-1:0]   op_a, op_b;
  logic [4*WIDTH-1:0] res, res_nx;
  logic               err, err_nx;
  logic [WIDTH-1:0]   s_nor, s_or, s_xor, s_xnor;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // NOTE: the default is assigned first so no path leaves state_nx unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid)     state_nx = RUN;
      RUN:     if (opcnt == 2'd3) state_nx = DONE;
      DONE:    if (out_ready)    state_nx = IDLE;
      default:                   state_nx = IDLE;
    endcase
  end

  // Result word as it will look after this edge's capture; the consistency
  // flag is derived from it so slot 3 is included when entering DONE.
  always_comb begin
    res_nx = res;
    res_nx[opcnt*WIDTH +: WIDTH] = lu_res;
    s_nor  = res_nx[0*WIDTH +: WIDTH];
    s_or   = res_nx[1*WIDTH +: WIDTH];
    s_xor  = res_nx[2*WIDTH +: WIDTH];
    s_xnor = res_nx[3*WIDTH +: WIDTH];
    err_nx = |((s_nor ^ ~s_or) | (s_xnor ^ ~s_xor));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opcnt <= 2'd0;
      op_a  <= '0;
      op_b  <= '0;
      res   <= '0;
      err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            op_a  <= in_a;
            op_b  <= in_b;
            opcnt <= 2'd0;
          end
        end
        RUN: begin
          res   <= res_nx;
          opcnt <= opcnt + 2'd1;
          if (opcnt == 2'd3) err <= err_nx;
        end
        default: ;
      endcase
    end
  end

  // in_ready is gated by rst_n so it reads low for the whole reset window.
  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = (state == DONE);
  assign lu_op     = (state == RUN) ? opcnt : 2'b00;
  assign lu_a      = op_a;
  assign lu_b      = op_b;
  assign out_data  = res;
  assign out_err   = err;

endmodule

// File: tb/tb_lu_sequencer.sv
// Directed bench for lu_sequencer: a WIDTH=1 instance with an optionally faulty
// LU model for vectors and corner cases, and a WIDTH=4 instance for streaming.
module tb_lu_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] lu_f(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    case (op)
      2'b00:   lu_f = ~(a | b);
      2'b01:   lu_f = a | b;
      2'b10:   lu_f = a ^ b;
      default: lu_f = ~(a ^ b);
    endcase
  endfunction

  // WIDTH=1 instance
  logic       in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b0, out_err1;
  logic [0:0] in_a1 = '0, in_b1 = '0, lu_a1, lu_b1, lu_res1;
  logic [1:0] lu_op1;
  logic [3:0] out_data1, lu_full1;
  logic       fault = 1'b0;

  assign lu_full1 = lu_f({3'b0, lu_a1}, {3'b0, lu_b1}, lu_op1);
  assign lu_res1  = (fault && lu_op1 == 2'b00) ? 1'b1 : lu_full1[0];

  lu_sequencer #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_a(in_a1), .in_b(in_b1),
    .lu_a(lu_a1), .lu_b(lu_b1), .lu_op(lu_op1), .lu_res(lu_res1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1), .out_err(out_err1)
  );

  // WIDTH=4 instance
  logic        in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b0, out_err4;
  logic [3:0]  in_a4 = '0, in_b4 = '0, lu_a4, lu_b4, lu_res4;
  logic [1:0]  lu_op4;
  logic [15:0] out_data4;

  assign lu_res4 = lu_f(lu_a4, lu_b4, lu_op4);

  lu_sequencer #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_a(in_a4), .in_b(in_b4),
    .lu_a(lu_a4), .lu_b(lu_b4), .lu_op(lu_op4), .lu_res(lu_res4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4), .out_err(out_err4)
  );

  typedef struct {
    logic       a;
    logic       b;
    logic       flt;
    logic [3:0] exp_data;
    logic       exp_err;
  } vec_t;

  vec_t vecs[5];

  // Full transaction on the WIDTH=1 instance, checking the op walk and handshakes.
  task automatic txn1(input logic a, input logic b, input logic [3:0] exp_data, input logic exp_err);
    @(negedge clk);
    check("accept_ready", in_ready1, 1);
    in_valid1 = 1'b1; in_a1 = a; in_b1 = b;
    @(negedge clk);
    in_valid1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("run%0d_op", k), lu_op1, k);
      check($sformatf("run%0d_a", k), {lu_a1, lu_b1}, {a, b});
      check($sformatf("run%0d_rdy_vld", k), {in_ready1, out_valid1}, 2'b00);
      @(negedge clk);
    end
    check("done_valid", out_valid1, 1);
    check("done_ready", in_ready1, 0);
    check("done_data", out_data1, exp_data);
    check("done_err", out_err1, exp_err);
    out_ready1 = 1'b1;
    @(negedge clk);
    out_ready1 = 1'b0;
    check("post_xfer", {in_ready1, out_valid1, lu_op1}, 4'b1000);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{a: 1'b0, b: 1'b1, flt: 1'b0, exp_data: 4'b0110, exp_err: 1'b0};
    vecs[1] = '{a: 1'b1, b: 1'b1, flt: 1'b0, exp_data: 4'b1010, exp_err: 1'b0};
    vecs[2] = '{a: 1'b0, b: 1'b0, flt: 1'b0, exp_data: 4'b1001, exp_err: 1'b0};
    vecs[3] = '{a: 1'b1, b: 1'b0, flt: 1'b0, exp_data: 4'b0110, exp_err: 1'b0};
    vecs[4] = '{a: 1'b0, b: 1'b1, flt: 1'b1, exp_data: 4'b0111, exp_err: 1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready1, 0);
    check("rst_out_valid", out_valid1, 0);
    check("rst_out_data", out_data1, 0);
    check("rst_out_err", out_err1, 0);
    check("rst_lu", {lu_a1, lu_b1, lu_op1}, 0);
    check("rst_w4", {out_valid4, out_data4, lu_a4, lu_b4}, 0);
    rst_n = 1'b1;
    #1;
    check("rst_release_ready", in_ready1, 1);

    foreach (vecs[i]) begin
      fault = vecs[i].flt;
      txn1(vecs[i].a, vecs[i].b, vecs[i].exp_data, vecs[i].exp_err);
    end
    fault = 1'b0;

    // Backpressure in DONE with a competing operand pair offered
    @(negedge clk);
    in_valid1 = 1'b1; in_a1 = 1'b0; in_b1 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0;
    repeat (4) @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("bp%0d_valid", c), out_valid1, 1);
      check($sformatf("bp%0d_data", c), {out_data1, out_err1}, {4'b0110, 1'b0});
      check($sformatf("bp%0d_ready", c), in_ready1, 0);
      in_valid1 = (c == 0); in_a1 = 1'b1; in_b1 = 1'b1;
      @(negedge clk);
    end
    in_valid1 = 1'b0;
    check("bp_hold_valid", out_valid1, 1);
    out_ready1 = 1'b1;
    @(negedge clk);
    out_ready1 = 1'b0;
    check("bp_xfer", {in_ready1, out_valid1}, 2'b10);
    check("bp_not_taken", {lu_a1, lu_b1}, 2'b01);

    // Reset in RUN at opcnt=2
    @(negedge clk);
    in_valid1 = 1'b1; in_a1 = 1'b1; in_b1 = 1'b0;
    @(negedge clk);
    in_valid1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_run_op", lu_op1, 2);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_ready_low", in_ready1, 0);
    rst_n = 1'b1;
    #1;
    check("mid_rst_ready", in_ready1, 1);
    check("mid_rst_state", {out_valid1, lu_op1}, 0);
    check("mid_rst_data", {out_data1, out_err1}, 0);
    check("mid_rst_ops", {lu_a1, lu_b1}, 0);
    begin
      logic seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (out_valid1) seen = 1'b1;
      end
      check("mid_rst_no_valid", seen, 0);
    end
    txn1(vecs[1].a, vecs[1].b, vecs[1].exp_data, vecs[1].exp_err);

    // WIDTH=4 streaming: two back-to-back pairs with out_ready held high
    begin
      logic [15:0] exp4[2];
      int acc_cyc[2];
      int nacc = 0;
      int nout = 0;
      logic accepting;
      exp4[0] = 16'h96E1;
      exp4[1] = 16'h9678;
      acc_cyc[0] = 0; acc_cyc[1] = 0;
      @(negedge clk);
      in_valid4 = 1'b1; in_a4 = 4'b1100; in_b4 = 4'b1010; out_ready4 = 1'b1;
      for (int c = 0; c < 40 && nout < 2; c++) begin
        if (out_valid4) begin
          check($sformatf("w4_data%0d", nout), out_data4, exp4[nout]);
          check($sformatf("w4_err%0d", nout), out_err4, 0);
          nout++;
        end
        accepting = in_valid4 && in_ready4;
        if (accepting && nacc < 2) begin
          acc_cyc[nacc] = c;
          nacc++;
        end
        @(negedge clk);
        if (accepting) begin
          if (nacc == 1) begin
            in_a4 = 4'b0011; in_b4 = 4'b0101;
          end else begin
            in_valid4 = 1'b0;
          end
        end
      end
      in_valid4 = 1'b0;
      out_ready4 = 1'b0;
      check("w4_outputs_seen", nout, 2);
      check("w4_accepts_seen", nacc, 2);
      check("w4_interval", acc_cyc[1] - acc_cyc[0], 6);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lu_sequencer.md
# lu_sequencer

Initiator-side controller for the bitwise logic unit (NOR/OR/XOR/XNOR with a 2-bit operation select). It accepts one operand pair over a valid/ready handshake and drives the LU's operand and select inputs through all four operations in turn. It samples each LU result and returns the four results as one packed word over a second valid/ready handshake. It also flags results that are not internally consistent (NOR must equal ~OR, XNOR must equal ~XOR).

## Interface
Parameters:
- WIDTH, default 1: operand width; the LU operates bitwise on WIDTH bits.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  sequencer can accept an operand pair.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- lu_a  out  WIDTH  operand A driven to the LU.
- lu_b  out  WIDTH  operand B driven to the LU.
- lu_op  out  2  LU select: 00 NOR, 01 OR, 10 XOR, 11 XNOR.
- lu_res  in  WIDTH  LU result; combinational from lu_a/lu_b/lu_op.
- out_valid  out  1  result word available.
- out_ready  in  1  consumer takes the result word.
- out_data  out  4*WIDTH  packed result {XNOR, XOR, OR, NOR}; NOR is in the LSBs.
- out_err  out  1  consistency fault in out_data.

## Operation
- The FSM has three states: IDLE, RUN and DONE. A 2-bit op counter, opcnt, is used only in RUN.
- IDLE:
  - in_ready=1, lu_op=00.
  - On in_valid&&in_ready, latch in_a/in_b into operand registers, clear opcnt, and go to RUN.
- RUN:
  - lu_a/lu_b come from the operand registers. lu_op=opcnt.
  - At each rising edge, capture lu_res into slot opcnt of the result register, then increment opcnt.
  - After the edge that captures slot 3, go to DONE.
- DONE:
  - out_valid=1. out_data and out_err are held stable.
  - On out_valid&&out_ready, go to IDLE.
  - lu_op=00.
- out_err is computed when entering DONE: (NOR slot != ~OR slot) | (XNOR slot != ~XOR slot), evaluated bitwise and OR-reduced.
- in_ready=0 in RUN and DONE. in_valid is ignored there, and in_a/in_b are not sampled.
- lu_a/lu_b hold the last latched operands in IDLE and DONE.
- out_data holds its last value after returning to IDLE. out_valid is the qualifier.
- Reset (rst_n low at a rising edge), including mid-RUN or mid-DONE:
  - state goes to IDLE, opcnt=0.
  - the operand registers, result register and out_err clear to 0.
  - the in-flight transaction is discarded; no out_valid follows.
- Reset values: in_ready=0 while rst_n is low and 1 on the first cycle after release. out_valid=0, out_data=0, out_err=0, lu_a=0, lu_b=0, lu_op=00.

## Timing
- Acceptance edge E0, then RUN for cycles 1–4 with lu_op = 00, 01, 10, 11. Captures happen at edges E1–E4.
- out_valid rises after E4. Accept-to-valid latency is 4 cycles.
- DONE lasts at least 1 cycle. The output transfer occurs at the edge where out_valid&&out_ready; in_ready is high in the following cycle.
- With in_valid and out_ready held high, throughput is one transaction per 6 cycles.
- lu_res must settle within the same cycle as lu_op/lu_a/lu_b. There is no pipeline stage in the LU path.
- Under backpressure (out_ready low), out_valid, out_data and out_err stay stable until the transfer.

## Test plan
- WIDTH=1, LU attached, in_a=0, in_b=1 → lu_op sequence 00,01,10,11 on cycles 1–4; out_data=4'b0110, out_err=0, out_valid after 4 cycles.
- WIDTH=1, in_a=1, in_b=1 → out_data=4'b1010, out_err=0. in_ready low from acceptance until the cycle after the transfer.
- WIDTH=4, in_a=4'b1100, in_b=4'b1010, out_ready held high, in_valid held high with two back-to-back pairs → first out_data=16'h96E1; second accepted exactly 6 cycles after the first.
- out_ready low for 3 cycles in DONE while in_valid pulses with a new pair → out_data stable, new pair not accepted (in_ready=0), transfer on the first cycle out_ready=1.
- Faulty LU model forcing lu_res=1 when lu_op=00, in_a=0, in_b=1 (WIDTH=1) → out_data=4'b0111, out_err=1.
- rst_n low for 1 cycle during RUN at opcnt=2 → next cycle IDLE with in_ready=1, out_valid=0, lu_op=00, out_data=0, out_err=0; no out_valid until a new transaction completes.
